// File: rtl/reg_operand_stage_if.sv
// Operand stage bus: decode handshake, register-file ports, writeback, execute handshake.
interface reg_operand_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_rs1;
  logic [2:0]       in_rs2;
  logic [2:0]       in_rd;
  logic             in_rd_we;
  logic [2:0]       rf_src_one;
  logic [2:0]       rf_src_two;
  logic [WIDTH-1:0] rf_out_one;
  logic [WIDTH-1:0] rf_out_two;
  logic [2:0]       rf_dest;
  logic             rf_write_enable;
  logic [WIDTH-1:0] rf_data_in;
  logic             wb_valid;
  logic [2:0]       wb_dest;
  logic [WIDTH-1:0] wb_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_op_one;
  logic [WIDTH-1:0] out_op_two;
  logic [2:0]       out_rd;
  logic             out_rd_we;

  // Stage side.
  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rd_we,
    input  rf_out_one, rf_out_two,
    input  wb_valid, wb_dest, wb_data,
    input  out_ready,
    output in_ready, rf_src_one, rf_src_two,
    output rf_dest, rf_write_enable, rf_data_in,
    output out_valid, out_op_one, out_op_two, out_rd, out_rd_we
  );

  // Environment side (decode, register file, writeback, execute).
  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_rd_we,
    output rf_out_one, rf_out_two,
    output wb_valid, wb_dest, wb_data,
    output out_ready,
    input  in_ready, rf_src_one, rf_src_two,
    input  rf_dest, rf_write_enable, rf_data_in,
    input  out_valid, out_op_one, out_op_two, out_rd, out_rd_we
  );
endinterface

// File: rtl/reg_operand_stage.sv
// Decode-to-execute operand stage: register-file read/write routing, writeback
// bypass into the captured operands, and a pending-write scoreboard that stalls
// issue on RAW/WAW hazards.

// Per-operand source selection: zero register, then writeback bypass, then RF data.
module reg_operand_sel #(
  parameter int WIDTH    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic [2:0]       src_i,
  input  logic [WIDTH-1:0] rf_data_i,
  input  logic             wb_valid_i,
  input  logic [2:0]       wb_dest_i,
  input  logic [WIDTH-1:0] wb_data_i,
  output logic [WIDTH-1:0] op_o
);
  // RF reads return the pre-write value, so a same-cycle writeback must be bypassed.
  always_comb begin
    op_o = rf_data_i;
    if (ZERO_REG != 0 && src_i == 3'd0)           op_o = '0;
    else if (wb_valid_i && wb_dest_i == src_i)    op_o = wb_data_i;
  end
endmodule

module reg_operand_stage #(
  parameter int WIDTH    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  reg_operand_stage_if.slave  bus
);
  localparam int         NUM_OPS = 2;
  localparam logic [7:0] ZMASK   = (ZERO_REG != 0) ? 8'hFE : 8'hFF;

  logic [7:0] pending_q, pending_d;
  logic [7:0] wb_hit, set_vec, pend_eff;
  logic       raw1, raw2, waw, ready, issue;

  logic                         out_valid_q, out_valid_d;
  logic [NUM_OPS-1:0][WIDTH-1:0] op_q, op_d, op_sel;
  logic [NUM_OPS-1:0][2:0]       src;
  logic [NUM_OPS-1:0][WIDTH-1:0] rf_data;
  logic [2:0]                   rd_q, rd_d;
  logic                         rd_we_q, rd_we_d;

  assign src     = {bus.in_rs2, bus.in_rs1};
  assign rf_data = {bus.rf_out_two, bus.rf_out_one};

  // Register file ports are pure pass-through.
  assign bus.rf_src_one      = bus.in_rs1;
  assign bus.rf_src_two      = bus.in_rs2;
  assign bus.rf_dest         = bus.wb_dest;
  assign bus.rf_write_enable = bus.wb_valid;
  assign bus.rf_data_in      = bus.wb_data;

  genvar g;
  generate
    for (g = 0; g < NUM_OPS; g++) begin : g_op
      reg_operand_sel #(.WIDTH(WIDTH), .ZERO_REG(ZERO_REG)) u_sel (
        .src_i      (src[g]),
        .rf_data_i  (rf_data[g]),
        .wb_valid_i (bus.wb_valid),
        .wb_dest_i  (bus.wb_dest),
        .wb_data_i  (bus.wb_data),
        .op_o       (op_sel[g])
      );
    end
  endgenerate

  // Hazard detection: a pending register being written back this cycle is already free.
  always_comb begin
    wb_hit = '0;
    if (bus.wb_valid) wb_hit[bus.wb_dest] = 1'b1;
    pend_eff = pending_q & ~wb_hit & ZMASK;
    raw1     = pend_eff[bus.in_rs1];
    raw2     = pend_eff[bus.in_rs2];
    waw      = bus.in_rd_we && pend_eff[bus.in_rd];
    ready    = (!out_valid_q || bus.out_ready) && !raw1 && !raw2 && !waw;
    issue    = bus.in_valid && ready;
  end

  assign bus.in_ready = ready;

  // Scoreboard next state: set on issue beats clear on writeback (newer write outstanding).
  always_comb begin
    set_vec = '0;
    if (issue && bus.in_rd_we) set_vec[bus.in_rd] = 1'b1;
    set_vec   = set_vec & ZMASK;
    pending_d = (pending_q & ~wb_hit) | set_vec;
  end

  // Output register next state: load on issue, drain on consume, hold under backpressure.
  always_comb begin
    out_valid_d = out_valid_q;
    op_d        = op_q;
    rd_d        = rd_q;
    rd_we_d     = rd_we_q;
    if (issue) begin
      out_valid_d = 1'b1;
      op_d        = op_sel;
      rd_d        = bus.in_rd;
      rd_we_d     = bus.in_rd_we;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset drops any in-flight instruction and all pending writes.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      op_q        <= '0;
      rd_q        <= '0;
      rd_we_q     <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      rd_we_q     <= rd_we_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_op_one = op_q[0];
  assign bus.out_op_two = op_q[1];
  assign bus.out_rd     = rd_q;
  assign bus.out_rd_we  = rd_we_q;
endmodule

// File: tb/tb_reg_operand_stage.sv
// Bench for reg_operand_stage: directed scenarios then random traffic, all checked
// against an architectural model (register array + pending set + output slot).
module tb_reg_operand_stage;
  localparam int W  = 32;
  localparam int ZR = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_operand_stage_if #(.WIDTH(W)) bus ();

  reg_operand_stage #(.WIDTH(W), .ZERO_REG(ZR)) dut (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .bus      (bus.slave)
  );

  int ncmp = 0;
  int nfail = 0;

  // Model state.
  logic [W-1:0] regs [8];
  bit   [7:0]   m_pend;
  bit           m_ov;
  logic [W-1:0] m_op1, m_op2;
  logic [2:0]   m_rd;
  bit           m_we;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_ov = 0; m_op1 = '0; m_op2 = '0; m_rd = '0; m_we = 0;
  endtask

  task automatic drive(input bit v, input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic [2:0] rd, input bit we, input bit wbv,
                       input logic [2:0] wbd, input logic [W-1:0] wbdat, input bit ordy);
    bus.in_valid   = v;
    bus.in_rs1     = rs1;
    bus.in_rs2     = rs2;
    bus.in_rd      = rd;
    bus.in_rd_we   = we;
    bus.wb_valid   = wbv;
    bus.wb_dest    = wbd;
    bus.wb_data    = wbdat;
    bus.out_ready  = ordy;
    bus.rf_out_one = regs[rs1];
    bus.rf_out_two = regs[rs2];
  endtask

  function automatic bit hit(input logic [2:0] r);
    return bus.wb_valid && bus.wb_dest == r;
  endfunction

  function automatic bit haz(input logic [2:0] r);
    if (ZR != 0 && r == 3'd0) return 0;
    return m_pend[r] && !hit(r);
  endfunction

  function automatic bit exp_ready();
    return (!m_ov || bus.out_ready) && !haz(bus.in_rs1) && !haz(bus.in_rs2)
           && !(bus.in_rd_we && haz(bus.in_rd));
  endfunction

  function automatic logic [W-1:0] exp_op(input logic [2:0] r);
    if (ZR != 0 && r == 3'd0) return '0;
    if (hit(r)) return bus.wb_data;
    return regs[r];
  endfunction

  // One clock: check combinational outputs, advance model across the edge, check state.
  task automatic cycle();
    bit           iss;
    bit   [7:0]   np;
    logic [W-1:0] o1, o2;
    #1;
    chk("in_ready", bus.in_ready, exp_ready());
    chk("rf_src_one", bus.rf_src_one, bus.in_rs1);
    chk("rf_src_two", bus.rf_src_two, bus.in_rs2);
    chk("rf_dest", bus.rf_dest, bus.wb_dest);
    chk("rf_we", bus.rf_write_enable, bus.wb_valid);
    chk("rf_data_in", bus.rf_data_in, bus.wb_data);
    iss = bus.in_valid && exp_ready();
    o1  = exp_op(bus.in_rs1);
    o2  = exp_op(bus.in_rs2);
    np  = m_pend;
    for (int r = 0; r < 8; r++) begin
      if (hit(r[2:0])) np[r] = 0;
      if (iss && bus.in_rd_we && bus.in_rd == r[2:0] && !(ZR != 0 && r == 0)) np[r] = 1;
    end
    @(posedge clk);
    if (iss) begin
      m_ov = 1; m_op1 = o1; m_op2 = o2; m_rd = bus.in_rd; m_we = bus.in_rd_we;
    end else if (bus.out_ready) begin
      m_ov = 0;
    end
    m_pend = np;
    if (bus.wb_valid) regs[bus.wb_dest] = bus.wb_data;
    #1;
    chk("out_valid", bus.out_valid, m_ov);
    chk("out_op_one", bus.out_op_one, m_op1);
    chk("out_op_two", bus.out_op_two, m_op2);
    chk("out_rd", bus.out_rd, m_rd);
    chk("out_rd_we", bus.out_rd_we, m_we);
    chk("pending", dut.pending_q, m_pend);
  endtask

  initial begin
    logic [2:0] wd;
    for (int i = 0; i < 8; i++) regs[i] = 32'h11 * i;
    regs[0] = 32'hFFFF_FFFF;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, '0, 1);

    // Reset state.
    #2;
    chk("rst_pending", dut.pending_q, 8'h00);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_op_one", bus.out_op_one, '0);
    chk("rst_op_two", bus.out_op_two, '0);
    chk("rst_out_rd", bus.out_rd, '0);
    chk("rst_out_rd_we", bus.out_rd_we, 1'b0);
    #5 rst_n = 1'b1;

    // Basic issue.
    drive(1, 1, 2, 3, 1, 0, 0, '0, 1);
    cycle();
    chk("t1_op1", bus.out_op_one, 32'h11);
    chk("t1_op2", bus.out_op_two, 32'h22);
    chk("t1_rd", bus.out_rd, 3'd3);
    chk("t1_pend", dut.pending_q, 8'h08);

    // RAW stall on r3 until its writeback, which is bypassed.
    drive(1, 3, 2, 4, 0, 0, 0, '0, 1);
    repeat (3) cycle();
    chk("t2_stall", bus.in_ready, 1'b0);
    drive(1, 3, 2, 4, 0, 1, 3, 32'hDEAD, 1);
    #1 chk("t2_release", bus.in_ready, 1'b1);
    cycle();
    chk("t2_op1", bus.out_op_one, 32'hDEAD);
    chk("t2_pend", dut.pending_q, 8'h00);

    // New write to r5 in the same cycle its older write retires: stays pending.
    drive(1, 1, 2, 5, 1, 0, 0, '0, 1);
    cycle();
    drive(1, 1, 2, 5, 1, 1, 5, 32'h5555, 1);
    cycle();
    chk("t3_pend", dut.pending_q, 8'h20);
    drive(1, 5, 1, 6, 0, 0, 0, '0, 1);
    cycle();
    chk("t3_stall", bus.in_ready, 1'b0);
    drive(0, 0, 0, 0, 0, 1, 5, 32'h5A5A, 1);
    cycle();

    // Register zero: reads zero, never pending, never stalls.
    drive(1, 0, 0, 0, 1, 0, 0, '0, 1);
    cycle();
    chk("t4_op1", bus.out_op_one, '0);
    chk("t4_op2", bus.out_op_two, '0);
    chk("t4_pend", dut.pending_q, 8'h00);

    // Backpressure holds outputs; releasing it replaces them with no bubble.
    drive(1, 1, 2, 4, 1, 0, 0, '0, 1);
    cycle();
    drive(1, 2, 1, 6, 1, 0, 0, '0, 0);
    cycle();
    chk("t5_hold_rd", bus.out_rd, 3'd4);
    chk("t5_hold_valid", bus.out_valid, 1'b1);
    drive(1, 2, 1, 6, 1, 0, 0, '0, 1);
    cycle();
    chk("t5_new_rd", bus.out_rd, 3'd6);
    chk("t5_new_valid", bus.out_valid, 1'b1);

    // Asynchronous reset mid-stall.
    drive(0, 0, 0, 0, 0, 1, 4, 32'h4444, 1); cycle();
    drive(0, 0, 0, 0, 0, 1, 6, 32'h6666, 1); cycle();
    drive(1, 1, 1, 2, 1, 0, 0, '0, 1); cycle();
    drive(1, 1, 1, 3, 1, 0, 0, '0, 1); cycle();
    drive(0, 0, 0, 0, 0, 0, 0, '0, 0); cycle();
    chk("t6_pre_pend", dut.pending_q, 8'h0C);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_pend", dut.pending_q, 8'h00);
    chk("t6_rst_valid", bus.out_valid, 1'b0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      wd = 3'($urandom_range(0, 7));
      if (m_pend != 0 && $urandom_range(0, 1) == 1)
        while (!m_pend[wd]) wd = 3'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom), 3'($urandom), 3'($urandom),
            1'($urandom), 1'($urandom_range(0, 2) == 0), wd, $urandom,
            1'($urandom_range(0, 3) != 0));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
